// File: rtl/pipe_scroller.sv
// Playfield scroller: shifts COLS column words left once per tick, loads pipes or blank spacers
// at the right edge, and keeps a saturating 2-digit BCD score. Optional macro: SCROLLER_SPEEDUP_EN.
module pipe_scroller #(
  parameter int COLS     = 16,
  parameter int ROWS     = 16,
  parameter int TICK_DIV = 12_500_000,
  parameter int GAP_COLS = 3,
  parameter int BIRD_COL = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   freeze,
  input  logic [ROWS-1:0]        pipe_in,
  output logic                   pipe_req,
  output logic [COLS*ROWS-1:0]   grid,
  output logic                   step,
  output logic                   pipe_passed,
  output logic [3:0]             score_tens,
  output logic [3:0]             score_ones
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_COLS > 0) ? $clog2(GAP_COLS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_COLS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [TW-1:0]          tick_cnt_r;
  logic [GW-1:0]          gap_cnt_r;
  logic [COLS*ROWS-1:0]   grid_r;
  logic [3:0]             tens_r;
  logic [3:0]             ones_r;
  logic                   step_r;
  logic                   passed_r;

  logic                   start_s;
  logic                   scroll_s;
  logic                   load_s;
  logic                   bird_hit_s;
  logic [ROWS-1:0]        new_col_s;
  logic [7:0]             score_next_s;
  logic [TW-1:0]          period_last_s;

  // Saturating BCD increment of a {tens, ones} pair; 99 holds.
  function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (t == 4'd9 && o == 4'd9) begin
      r = {t, o};
    end else if (o == 4'd9) begin
      r = {t + 4'd1, 4'd0};
    end else begin
      r = {t, o + 4'd1};
    end
    return r;
  endfunction

`ifdef SCROLLER_SPEEDUP_EN
  logic [TW-1:0] period_last_r;

  // Tick period shrinks by TICK_DIV/8 per tens digit, never below TICK_DIV/4.
  function automatic logic [TW-1:0] speed_last(input logic [3:0] tens);
    int p;
    p = TICK_DIV - (TICK_DIV / 8) * int'(tens);
    p = (p < (TICK_DIV / 4)) ? (TICK_DIV / 4) : p;
    return TW'(p - 1);
  endfunction

  // Period register, only re-evaluated when the tick wraps so a running tick is never cut short.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_last_r <= TICK_LAST;
    end else if (start_s) begin
      period_last_r <= TICK_LAST;
    end else if (scroll_s) begin
      period_last_r <= speed_last(score_next_s[7:4]);
    end
  end

  assign period_last_s = period_last_r;
`else
  assign period_last_s = TICK_LAST;
`endif

  assign bird_hit_s   = |grid_r[BIRD_COL*ROWS +: ROWS];
  assign new_col_s    = load_s ? pipe_in : {ROWS{1'b0}};
  assign score_next_s = bird_hit_s ? bcd_inc(tens_r, ones_r) : {tens_r, ones_r};

  // Next-state and scroll decode; freeze is checked ahead of the tick so it beats a same-cycle scroll.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    scroll_s     = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = RUN;
          start_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next_s = IDLE;
        end else if (freeze) begin
          state_next_s = FROZEN;
        end else begin
          state_next_s = RUN;
          if (tick_cnt_r == period_last_s) begin
            scroll_s = 1'b1;
            load_s   = (gap_cnt_r == GAP_LAST);
          end else begin
            scroll_s = 1'b0;
            load_s   = 1'b0;
          end
        end
      end
      FROZEN: begin
        if (!enable) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FROZEN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Playfield, counters, score and the post-scroll pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grid_r     <= {(COLS*ROWS){1'b0}};
      tick_cnt_r <= {TW{1'b0}};
      gap_cnt_r  <= {GW{1'b0}};
      tens_r     <= 4'd0;
      ones_r     <= 4'd0;
      step_r     <= 1'b0;
      passed_r   <= 1'b0;
    end else begin
      step_r   <= scroll_s;
      passed_r <= scroll_s & bird_hit_s;
      if (start_s) begin
        grid_r     <= {(COLS*ROWS){1'b0}};
        tick_cnt_r <= {TW{1'b0}};
        gap_cnt_r  <= {GW{1'b0}};
        tens_r     <= 4'd0;
        ones_r     <= 4'd0;
      end else if (scroll_s) begin
        grid_r     <= {new_col_s, grid_r[COLS*ROWS-1:ROWS]};
        tick_cnt_r <= {TW{1'b0}};
        gap_cnt_r  <= load_s ? {GW{1'b0}} : gap_cnt_r + GW'(1);
        tens_r     <= score_next_s[7:4];
        ones_r     <= score_next_s[3:0];
      end else if (state_r == RUN && state_next_s == RUN) begin
        tick_cnt_r <= tick_cnt_r + TW'(1);
      end
    end
  end

  assign pipe_req    = load_s;
  assign grid        = grid_r;
  assign step        = step_r;
  assign pipe_passed = passed_r;
  assign score_tens  = tens_r;
  assign score_ones  = ones_r;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: a cycle-count/array model of the playfield checked every
// cycle, plus directed literal checks for reset, first-pipe timing, freeze, and score saturation.
module tb_pipe_scroller;

  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam int TICK = 4;
  localparam int GAP  = 2;
  localparam int BIRD = 12;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b0;
  logic                 freeze = 1'b0;
  logic [ROWS-1:0]      pipe_in = 16'h0000;
  logic                 pipe_req;
  logic [COLS*ROWS-1:0] grid;
  logic                 step;
  logic                 pipe_passed;
  logic [3:0]           score_tens;
  logic [3:0]           score_ones;

  int tests = 0;
  int fails = 0;

  // Model: mode 0 idle, 1 run, 2 frozen; cycles counted since run entry.
  int              m_mode = 0;
  int              m_cyc = 0;
  int              m_steps = 0;
  int              m_score = 0;
  logic [ROWS-1:0] m_cols [COLS];
  bit              m_step = 1'b0;
  bit              m_passed = 1'b0;

  pipe_scroller #(
    .COLS(COLS), .ROWS(ROWS), .TICK_DIV(TICK), .GAP_COLS(GAP), .BIRD_COL(BIRD)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .freeze(freeze), .pipe_in(pipe_in),
    .pipe_req(pipe_req), .grid(grid), .step(step), .pipe_passed(pipe_passed),
    .score_tens(score_tens), .score_ones(score_ones)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < COLS; c++) m_cols[c] = '0;
    m_cyc = 0;
    m_steps = 0;
    m_score = 0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_mode = 0;
      model_clear();
      m_step = 1'b0;
      m_passed = 1'b0;
    end else begin
      m_step = 1'b0;
      m_passed = 1'b0;
      case (m_mode)
        0: if (enable) begin m_mode = 1; model_clear(); end
        1: begin
          if (!enable) m_mode = 0;
          else if (freeze) m_mode = 2;
          else begin
            if (m_cyc % TICK == TICK - 1) begin
              m_passed = (m_cols[BIRD] != '0);
              for (int c = 0; c < COLS - 1; c++) m_cols[c] = m_cols[c+1];
              m_steps++;
              m_cols[COLS-1] = (m_steps % (GAP + 1) == 0) ? pipe_in : 16'h0000;
              if (m_passed && m_score < 99) m_score++;
              m_step = 1'b1;
            end
            m_cyc++;
          end
        end
        2: if (!enable) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  endtask

  function automatic logic [COLS*ROWS-1:0] model_grid();
    logic [COLS*ROWS-1:0] g;
    for (int c = 0; c < COLS; c++) g[c*ROWS +: ROWS] = m_cols[c];
    return g;
  endfunction

  function automatic bit model_req();
    return (m_mode == 1) && enable && !freeze && (m_cyc % TICK == TICK - 1)
           && ((m_steps + 1) % (GAP + 1) == 0);
  endfunction

  initial begin
    for (int c = 0; c < COLS; c++) m_cols[c] = '0;
    forever begin
      @(posedge clock or negedge reset);
      model_edge();
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      check("grid", 256'(grid), 256'(model_grid()));
      check("score_tens", 256'(score_tens), 256'(m_score / 10));
      check("score_ones", 256'(score_ones), 256'(m_score % 10));
      check("step", 256'(step), 256'(m_step));
      check("pipe_passed", 256'(pipe_passed), 256'(m_passed));
      check("pipe_req", 256'(pipe_req), 256'(model_req()));
    end
  end

  task automatic wait_step(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    n++;
    while (step !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({"timeout_", tag}, 256'(step), 256'(1'b1));
  endtask

  task automatic wait_pass(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    n++;
    while (pipe_passed !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({"timeout_", tag}, 256'(pipe_passed), 256'(1'b1));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("rst_grid", 256'(grid), 256'(0));
    check("rst_score", 256'({score_tens, score_ones}), 256'(8'h00));
    check("rst_req", 256'(pipe_req), 256'(0));
    check("rst_step", 256'(step), 256'(0));
    #1 reset = 1'b1;
    @(negedge clock);
    #1 enable = 1'b1;
    pipe_in = 16'h81FF;

    wait_step("s1"); check("s1_col15", 256'(grid[15*ROWS +: ROWS]), 256'(16'h0000));
    wait_step("s2"); check("s2_col15", 256'(grid[15*ROWS +: ROWS]), 256'(16'h0000));
    wait_step("s3"); check("s3_col15", 256'(grid[15*ROWS +: ROWS]), 256'(16'h81FF));
    check("model_s3_col15", 256'(m_cols[15]), 256'(16'h81FF));
    wait_step("s4"); check("s4_col15", 256'(grid[15*ROWS +: ROWS]), 256'(16'h0000));
    wait_step("s5"); check("s5_col15", 256'(grid[15*ROWS +: ROWS]), 256'(16'h0000));
    wait_step("s6"); check("s6_col12", 256'(grid[12*ROWS +: ROWS]), 256'(16'h81FF));
    check("s6_passed", 256'(pipe_passed), 256'(0));
    wait_step("s7");
    check("s7_passed", 256'(pipe_passed), 256'(1));
    check("s7_score", 256'({score_tens, score_ones}), 256'(8'h01));
    check("model_s7_score", 256'(m_score), 256'(1));

    // Freeze on the tick==3 cycle: the pending scroll must not happen.
    repeat (3) @(negedge clock);
    #1 freeze = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("frozen_no_step", 256'(step), 256'(0));
    end
    check("frozen_col11", 256'(grid[11*ROWS +: ROWS]), 256'(16'h81FF));
    #1 freeze = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("unfreeze_no_step", 256'(step), 256'(0));
    end
    check("frozen_score", 256'({score_tens, score_ones}), 256'(8'h01));
    #1 enable = 1'b0;
    @(negedge clock);
    #1 enable = 1'b1;
    pipe_in = 16'h0000;
    @(negedge clock);
    check("restart_grid", 256'(grid), 256'(0));
    check("restart_score", 256'({score_tens, score_ones}), 256'(8'h00));

    // All-zero pipes are blanks and never score.
    repeat (60) @(negedge clock);
    check("blank_score", 256'({score_tens, score_ones}), 256'(8'h00));
    #1 pipe_in = 16'hFFFF;
    wait_pass("full");
    check("full_score", 256'({score_tens, score_ones}), 256'(8'h01));
    #1 pipe_in = 16'h0001;
    for (int i = 0; i < 97; i++) wait_pass("run98");
    check("score98", 256'({score_tens, score_ones}), 256'(8'h98));
    wait_pass("p99");
    check("score99", 256'({score_tens, score_ones}), 256'(8'h99));
    wait_pass("p100");
    check("score_sat", 256'({score_tens, score_ones}), 256'(8'h99));
    check("model_sat", 256'(m_score), 256'(99));

    // Async reset in the middle of a pipe_req cycle.
    n = 0;
    @(negedge clock);
    while (pipe_req !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("timeout_req", 256'(pipe_req), 256'(1));
    #1 reset = 1'b0;
    #1;
    check("async_grid", 256'(grid), 256'(0));
    check("async_score", 256'({score_tens, score_ones}), 256'(8'h00));
    check("async_req", 256'(pipe_req), 256'(0));
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
